// File: rtl/prt_dptx_sdp_pkg.sv
// Shared types and constants for the DP TX SDP scheduler.
//   state_t      : scheduler FSM states
//   idx_w()      : index width helper (never returns 0)
//   SDP_PKT_ID / SDP_AE_TYPE : header byte values used by the packet generators
package prt_dptx_sdp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam int unsigned SDP_HDR_BYTE_W = 8;
  localparam logic [SDP_HDR_BYTE_W-1:0] SDP_PKT_ID  = 8'h01;
  localparam logic [SDP_HDR_BYTE_W-1:0] SDP_AE_TYPE = 8'hA1;

  // Width of an index into n items; at least 1 bit so n=1 still yields a legal vector.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prt_dptx_sdp_rr_arb.sv
// Combinational round-robin pick.
//   req     : per-channel request vector
//   ptr     : last granted channel; search starts at ptr+1 and wraps
//   gnt_idx : first requesting channel after ptr (circular)
//   gnt_vld : at least one request present
module prt_dptx_sdp_rr_arb
  import prt_dptx_sdp_pkg::*;
#(
  parameter int unsigned P_CH   = 4,
  parameter int unsigned P_CH_W = idx_w(P_CH)
) (
  input  logic [P_CH-1:0]   req,
  input  logic [P_CH_W-1:0] ptr,
  output logic [P_CH_W-1:0] gnt_idx,
  output logic              gnt_vld
);

  // Scan from the farthest offset down to the nearest so the nearest requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = P_CH; k >= 1; k--) begin
      if (req[P_CH_W'((32'(ptr) + 32'(k)) % P_CH)]) begin
        gnt_vld = 1'b1;
        gnt_idx = P_CH_W'((32'(ptr) + 32'(k)) % P_CH);
      end
    end
  end

endmodule

// File: rtl/prt_dptx_sdp_sched.sv
// Multi-channel SDP scheduler: per-channel packet buffers streamed round-robin on a
// valid/ready source during vertical blanking, with a per-window packet budget.
//   clk, rst_n            : clock, async active-low reset
//   vsync_in              : vsync level (high = sync); falling edge opens a window
//   cfg_en / cfg_rpt      : channel enable / repeat-every-frame mode
//   ld_stb/ld_ch/ld_beat/ld_data : buffer write port
//   cmt_stb/cmt_ch        : commit a channel (sets its pending bit)
//   sdp_ready             : sink ready
//   sdp_valid/sop/eop/ch/data : packet stream
//   ld_err                : pulse, write to the channel being sent was dropped
//   ovf                   : pulse, vsync fall while a window is still active
//   busy                  : scheduler not idle
module prt_dptx_sdp_sched
  import prt_dptx_sdp_pkg::*;
#(
  parameter int unsigned P_CH     = 4,
  parameter int unsigned P_BEATS  = 4,
  parameter int unsigned P_DATA_W = 32,
  parameter int unsigned P_MAX_VB = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          vsync_in,
  input  logic [P_CH-1:0]               cfg_en,
  input  logic [P_CH-1:0]               cfg_rpt,
  input  logic                          ld_stb,
  input  logic [idx_w(P_CH)-1:0]        ld_ch,
  input  logic [idx_w(P_BEATS)-1:0]     ld_beat,
  input  logic [P_DATA_W-1:0]           ld_data,
  input  logic                          cmt_stb,
  input  logic [idx_w(P_CH)-1:0]        cmt_ch,
  input  logic                          sdp_ready,
  output logic                          sdp_valid,
  output logic                          sdp_sop,
  output logic                          sdp_eop,
  output logic [idx_w(P_CH)-1:0]        sdp_ch,
  output logic [P_DATA_W-1:0]           sdp_data,
  output logic                          ld_err,
  output logic                          ovf,
  output logic                          busy
);

  localparam int unsigned CH_W   = idx_w(P_CH);
  localparam int unsigned BEAT_W = idx_w(P_BEATS);
  localparam int unsigned BUD_W  = idx_w(P_MAX_VB + 1);
  localparam int unsigned DEPTH  = P_CH * P_BEATS;
  localparam int unsigned ADDR_W = idx_w(DEPTH);

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(P_BEATS - 1);
  localparam logic [BUD_W-1:0]  BUD_MAX   = BUD_W'(P_MAX_VB);
  localparam logic [CH_W-1:0]   RR_INIT   = CH_W'(P_CH - 1);

  state_t              r_state;
  logic                r_vsync_q;
  logic [P_CH-1:0]     r_pend;
  logic [P_CH-1:0]     r_committed;
  logic [BUD_W-1:0]    r_budget;
  logic [CH_W-1:0]     r_rr;
  logic [CH_W-1:0]     r_sel;
  logic [BEAT_W-1:0]   r_beat;
  logic                r_valid;
  logic                r_sop;
  logic                r_eop;
  logic [CH_W-1:0]     r_ch;
  logic [P_DATA_W-1:0] r_data;
  logic                r_ld_err;
  logic                r_ovf;
  logic                r_busy;
  logic [P_DATA_W-1:0] r_buf [DEPTH];

  logic                w_trig;
  logic                w_eop_hs;
  logic                w_ld_hit;
  logic                w_ld_ok;
  logic [P_CH-1:0]     w_req;
  logic [P_CH-1:0]     w_pend_nxt;
  logic [CH_W-1:0]     w_gnt_idx;
  logic                w_gnt_vld;
  logic [BEAT_W-1:0]   w_beat_inc;

  function automatic logic [ADDR_W-1:0] f_addr(input logic [CH_W-1:0] ch,
                                               input logic [BEAT_W-1:0] b);
    return ADDR_W'(ch) * ADDR_W'(P_BEATS) + ADDR_W'(b);
  endfunction

  assign w_trig     = r_vsync_q & ~vsync_in;
  assign w_eop_hs   = (r_state == SEND) && sdp_ready && (r_beat == BEAT_LAST);
  assign w_ld_hit   = ld_stb && (r_state == SEND) && (ld_ch == r_sel);
  assign w_ld_ok    = ld_stb && !w_ld_hit && (32'(ld_ch) < P_CH) && (32'(ld_beat) < P_BEATS);
  assign w_req      = r_pend & cfg_en;
  assign w_beat_inc = r_beat + BEAT_W'(1);

  prt_dptx_sdp_rr_arb #(
    .P_CH   (P_CH),
    .P_CH_W (CH_W)
  ) u_arb (
    .req     (w_req),
    .ptr     (r_rr),
    .gnt_idx (w_gnt_idx),
    .gnt_vld (w_gnt_vld)
  );

  // Pending update: eop clear first, then frame repeat set, then commit (commit wins).
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_eop_hs) w_pend_nxt[r_sel] = 1'b0;
    if (w_trig)   w_pend_nxt = w_pend_nxt | (cfg_rpt & r_committed);
    if (cmt_stb)  w_pend_nxt[cmt_ch] = 1'b1;
  end

  // Packet buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_ld_ok) r_buf[f_addr(ld_ch, ld_beat)] <= ld_data;
  end

  // Scheduler FSM with registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_vsync_q   <= 1'b0;
      r_pend      <= '0;
      r_committed <= '0;
      r_budget    <= '0;
      r_rr        <= RR_INIT;
      r_sel       <= '0;
      r_beat      <= '0;
      r_valid     <= 1'b0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
      r_ch        <= '0;
      r_data      <= '0;
      r_ld_err    <= 1'b0;
      r_ovf       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_vsync_q <= vsync_in;
      r_ld_err  <= w_ld_hit;
      r_ovf     <= w_trig && (r_state != IDLE);
      r_pend    <= w_pend_nxt;
      if (cmt_stb) r_committed[cmt_ch] <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_trig) begin
            r_state <= ARB;
            r_busy  <= 1'b1;
          end
        end

        ARB: begin
          if (w_gnt_vld && (r_budget != '0)) begin
            r_state <= SEND;
            r_sel   <= w_gnt_idx;
            r_rr    <= w_gnt_idx;
            r_beat  <= '0;
            r_valid <= 1'b1;
            r_sop   <= 1'b1;
            r_eop   <= 1'b0;
            r_ch    <= w_gnt_idx;
            r_data  <= r_buf[f_addr(w_gnt_idx, '0)];
          end else begin
            r_budget <= '0;
            // A trigger landing on the closing ARB re-opens the window instead of being lost.
            if (!w_trig) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end

        SEND: begin
          if (sdp_ready) begin
            if (r_beat == BEAT_LAST) begin
              r_state <= ARB;
              r_valid <= 1'b0;
              r_sop   <= 1'b0;
              r_eop   <= 1'b0;
              if (r_budget != '0) r_budget <= r_budget - BUD_W'(1);
            end else begin
              r_beat <= w_beat_inc;
              r_sop  <= 1'b0;
              r_eop  <= (w_beat_inc == BEAT_LAST);
              r_data <= r_buf[f_addr(r_sel, w_beat_inc)];
            end
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase

      // Budget reload on every trigger takes priority over the eop decrement.
      if (w_trig) r_budget <= BUD_MAX;
    end
  end

  assign sdp_valid = r_valid;
  assign sdp_sop   = r_sop;
  assign sdp_eop   = r_eop;
  assign sdp_ch    = r_ch;
  assign sdp_data  = r_data;
  assign ld_err    = r_ld_err;
  assign ovf       = r_ovf;
  assign busy      = r_busy;

endmodule

// File: tb/tb_prt_dptx_sdp_sched.sv
// Scoreboard bench for prt_dptx_sdp_sched: stimulus pushes expected beats, a
// negedge monitor pops and compares on every handshake.
module tb_prt_dptx_sdp_sched;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        vsync_in;
  logic [3:0]  cfg_en;
  logic [3:0]  cfg_rpt;
  logic        ld_stb;
  logic [1:0]  ld_ch;
  logic [1:0]  ld_beat;
  logic [31:0] ld_data;
  logic        cmt_stb;
  logic [1:0]  cmt_ch;
  logic        sdp_ready;
  logic        sdp_valid;
  logic        sdp_sop;
  logic        sdp_eop;
  logic [1:0]  sdp_ch;
  logic [31:0] sdp_data;
  logic        ld_err;
  logic        ovf;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          beats_seen = 0;
  int          cyc = 0;
  int          eop_cyc = 0;
  bit          have_eop = 1'b0;
  bit          prev_valid = 1'b0;
  bit          prev_ready = 1'b0;
  beat_t       prev_beat;
  beat_t       exp_q[$];
  logic [31:0] mdl [4][4];

  prt_dptx_sdp_sched #(
    .P_CH     (4),
    .P_BEATS  (4),
    .P_DATA_W (32),
    .P_MAX_VB (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vsync_in  (vsync_in),
    .cfg_en    (cfg_en),
    .cfg_rpt   (cfg_rpt),
    .ld_stb    (ld_stb),
    .ld_ch     (ld_ch),
    .ld_beat   (ld_beat),
    .ld_data   (ld_data),
    .cmt_stb   (cmt_stb),
    .cmt_ch    (cmt_ch),
    .sdp_ready (sdp_ready),
    .sdp_valid (sdp_valid),
    .sdp_sop   (sdp_sop),
    .sdp_eop   (sdp_eop),
    .sdp_ch    (sdp_ch),
    .sdp_data  (sdp_data),
    .ld_err    (ld_err),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: scoreboard pop on handshake, stall stability, inter-packet gap.
  always @(negedge clk) begin
    beat_t got;
    beat_t e;
    cyc++;
    got = '{ch: sdp_ch, data: sdp_data, sop: sdp_sop, eop: sdp_eop};
    if (rst_n) begin
      if (prev_valid && !prev_ready) begin
        checks++;
        if (!sdp_valid || got !== prev_beat) begin
          errors++;
          $display("FAIL stall_hold got=%h v=%0b exp=%h", got, sdp_valid, prev_beat);
        end
      end
      if (sdp_valid && sdp_sop && !prev_valid && have_eop && (cyc - eop_cyc) <= 4) begin
        checks++;
        if (cyc - eop_cyc != 2) begin
          errors++;
          $display("FAIL pkt_gap got=%0d exp=2", cyc - eop_cyc);
        end
      end
      if (sdp_valid && sdp_ready) begin
        checks++;
        beats_seen++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got=%h exp=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL beat got=%h exp=%h", got, e);
          end
        end
        if (sdp_eop) begin
          have_eop = 1'b1;
          eop_cyc  = cyc;
        end
      end
      prev_valid = sdp_valid;
      prev_ready = sdp_ready;
      prev_beat  = got;
    end else begin
      prev_valid = 1'b0;
      have_eop   = 1'b0;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic load_ch(input int ch, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] d [4];
    d = '{d0, d1, d2, d3};
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      ld_stb  = 1'b1;
      ld_ch   = 2'(ch);
      ld_beat = 2'(b);
      ld_data = d[b];
      mdl[ch][b] = d[b];
    end
    @(posedge clk); #1 ld_stb = 1'b0;
  endtask

  task automatic commit(input int ch);
    @(posedge clk); #1;
    cmt_stb = 1'b1;
    cmt_ch  = 2'(ch);
    @(posedge clk); #1 cmt_stb = 1'b0;
  endtask

  task automatic push_pkt(input int ch);
    for (int b = 0; b < 4; b++)
      exp_q.push_back('{ch: 2'(ch), data: mdl[ch][b], sop: (b == 0), eop: (b == 3)});
  endtask

  task automatic vsync_fall();
    @(posedge clk); #1 vsync_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 vsync_in = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout got=busy exp=idle", tag);
    end
  endtask

  task automatic wait_valid(input string tag, input int want_ch, input bit need_sop,
                            input bit need_eop, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sdp_valid && (want_ch < 0 || 32'(sdp_ch) == want_ch) &&
                 (!need_sop || sdp_sop) && (!need_eop || sdp_eop)) && n < 200);
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_wait_timeout got=none exp=valid", tag);
    end
  endtask

  initial begin
    int n;
    int b0;
    int ovf_cnt;
    bit [3:0] rdy_pat [8];

    rst_n = 1'b0; vsync_in = 1'b0; cfg_en = '0; cfg_rpt = '0;
    ld_stb = 1'b0; ld_ch = '0; ld_beat = '0; ld_data = '0;
    cmt_stb = 1'b0; cmt_ch = '0; sdp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(sdp_valid), 64'(0));
    chk("rst_sop",   64'(sdp_sop),   64'(0));
    chk("rst_eop",   64'(sdp_eop),   64'(0));
    chk("rst_ch",    64'(sdp_ch),    64'(0));
    chk("rst_data",  64'(sdp_data),  64'(0));
    chk("rst_ld_err",64'(ld_err),    64'(0));
    chk("rst_ovf",   64'(ovf),       64'(0));
    chk("rst_busy",  64'(busy),      64'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: single one-shot packet on ch0, latency and no resend
    load_ch(0, 32'h01A11000, 32'hDEADBEEF, 32'h00000001, 32'h00000002);
    cfg_en = 4'b0001;
    commit(0);
    push_pkt(0);
    vsync_fall();
    n = 0;
    do begin @(negedge clk); n++; end while (!sdp_valid && n < 20);
    chk("t1_first_valid_lat", 64'(n), 64'(3));
    chk("t1_first_ch", 64'(sdp_ch), 64'(0));
    wait_idle("t1");
    chk("t1_drain", 64'(exp_q.size()), 64'(0));
    b0 = beats_seen;
    vsync_fall();
    wait_idle("t1b");
    chk("t1_no_resend", 64'(beats_seen), 64'(b0));

    // 2: repeat channels ch1, ch2 over three frames
    do_reset();
    load_ch(1, 32'h01A21100, 32'h11111111, 32'h11112222, 32'h1111FFFF);
    load_ch(2, 32'h01A31200, 32'h22220000, 32'h22221111, 32'h2222EEEE);
    cfg_en = 4'b0110; cfg_rpt = 4'b0110;
    commit(1);
    commit(2);
    for (int f = 0; f < 3; f++) begin
      push_pkt(1);
      push_pkt(2);
      vsync_fall();
      wait_idle("t2");
      chk("t2_drain", 64'(exp_q.size()), 64'(0));
    end

    // 3: all four pending, budget 2, round-robin across frames
    do_reset();
    cfg_rpt = 4'b0000;
    load_ch(3, 32'h01A41300, 32'h33330000, 32'h3333ABCD, 32'h3333FFFF);
    load_ch(0, 32'h01A11000, 32'hDEADBEEF, 32'h00000001, 32'h00000002);
    cfg_en = 4'b1111;
    for (int c = 0; c < 4; c++) commit(c);
    push_pkt(0); push_pkt(1);
    vsync_fall();
    wait_idle("t3a");
    chk("t3_frame1_drain", 64'(exp_q.size()), 64'(0));
    push_pkt(2); push_pkt(3);
    vsync_fall();
    wait_valid("t3_last_eop", 3, 1'b0, 1'b1, n);
    @(negedge clk);
    chk("t3_busy_arb", 64'(busy), 64'(1));
    chk("t3_gap_valid", 64'(sdp_valid), 64'(0));
    @(negedge clk);
    chk("t3_busy_drop", 64'(busy), 64'(0));
    chk("t3_frame2_drain", 64'(exp_q.size()), 64'(0));
    b0 = beats_seen;
    vsync_fall();
    wait_idle("t3c");
    chk("t3_frame3_empty", 64'(beats_seen), 64'(b0));

    // 4: ready stalls during a packet
    do_reset();
    cfg_en = 4'b1000;
    commit(3);
    push_pkt(3);
    vsync_fall();
    wait_valid("t4", 3, 1'b1, 1'b0, n);
    rdy_pat = '{4'd0, 4'd0, 4'd1, 4'd0, 4'd1, 4'd1, 4'd0, 4'd1};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 sdp_ready = rdy_pat[i][0];
    end
    @(posedge clk); #1 sdp_ready = 1'b1;
    wait_idle("t4");
    chk("t4_drain", 64'(exp_q.size()), 64'(0));

    // 5a: write to sending channel dropped, other channel write proceeds
    do_reset();
    load_ch(0, 32'h01A11000, 32'hDEADBEEF, 32'h00000001, 32'h00000002);
    load_ch(1, 32'h01A21100, 32'h11111111, 32'h11112222, 32'h1111FFFF);
    cfg_en = 4'b0001;
    commit(0);
    push_pkt(0);
    vsync_fall();
    wait_valid("t5a", 0, 1'b1, 1'b0, n);
    @(posedge clk); #1;
    ld_stb = 1'b1; ld_ch = 2'd0; ld_beat = 2'd1; ld_data = 32'h55555555;
    @(posedge clk); #1;
    ld_ch = 2'd1; ld_beat = 2'd0; ld_data = 32'h01A2AAAA;
    mdl[1][0] = 32'h01A2AAAA;
    @(negedge clk);
    chk("t5_ld_err_pulse", 64'(ld_err), 64'(1));
    @(posedge clk); #1 ld_stb = 1'b0;
    @(negedge clk);
    chk("t5_ld_err_other_ch", 64'(ld_err), 64'(0));
    wait_idle("t5a");
    // 5b: resend shows buffer intact; commit on eop keeps pend set
    commit(0);
    push_pkt(0);
    push_pkt(0);
    vsync_fall();
    wait_valid("t5b", 0, 1'b0, 1'b1, n);
    cmt_stb = 1'b1; cmt_ch = 2'd0;
    @(posedge clk); #1 cmt_stb = 1'b0;
    wait_idle("t5b");
    chk("t5_cmt_eop_drain", 64'(exp_q.size()), 64'(0));
    // 5c: ch1 carries the accepted write
    cfg_en = 4'b0011;
    commit(1);
    push_pkt(1);
    vsync_fall();
    wait_idle("t5c");
    chk("t5_ch1_drain", 64'(exp_q.size()), 64'(0));

    // 6a: vsync fall during SEND -> ovf, budget reload gives a third packet
    do_reset();
    cfg_en = 4'b0111;
    commit(0); commit(1); commit(2);
    push_pkt(0); push_pkt(1); push_pkt(2);
    vsync_fall();
    wait_valid("t6a", 1, 1'b1, 1'b0, n);
    @(posedge clk); #1 vsync_in = 1'b1;
    @(posedge clk); #1 vsync_in = 1'b0;
    ovf_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (ovf) ovf_cnt++;
    end
    chk("t6_ovf_pulses", 64'(ovf_cnt), 64'(1));
    wait_idle("t6a");
    chk("t6_reload_drain", 64'(exp_q.size()), 64'(0));

    // 6b: reset mid-packet aborts, pend cleared
    cfg_en = 4'b1111;
    commit(3);
    push_pkt(3);
    vsync_fall();
    wait_valid("t6b", 3, 1'b1, 1'b0, n);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t6_rst_valid", 64'(sdp_valid), 64'(0));
    chk("t6_rst_busy", 64'(busy), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    b0 = beats_seen;
    vsync_fall();
    wait_idle("t6b");
    chk("t6_pend_cleared", 64'(beats_seen), 64'(b0));
    chk("final_drain", 64'(exp_q.size()), 64'(0));

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
